// File: rtl/controlador_elevador_fila.sv
// controlador_elevador_fila: elevator controller with a built-in FIFO of
// (origem,destino) requests. Each head request is served by travelling to
// origem, opening the door, travelling to destino, opening the door and
// then popping the request.
//
// Optional feature macro: PARADA_EMERG_EN (adds the "parar" emergency stop).
//
// Ports:
//   clock, reset            rising-edge clock, async active-high reset
//   iniciar                 leaves INICIAL
//   novaEntrada             one-cycle request strobe (edge-detected upstream)
//   andarOrigem/Destino     request floors, sampled with novaEntrada
//   parar                   emergency stop (PARADA_EMERG_EN only)
//   andarAtual              current floor
//   sobe/desce/portaAberta  cabin moving up / down, door open
//   pedidoAceito/Rejeitado  one-cycle pulse the cycle after a strobe
//   filaCheia/filaVazia     FIFO full / empty
//   db_estado               current state code
module controlador_elevador_fila #(
  parameter int unsigned NUM_ANDARES = 8,
  parameter int unsigned FILA_PROF   = 4,
  parameter int unsigned T_ANDAR     = 4,
  parameter int unsigned T_PORTA     = 3
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       iniciar,
  input  logic       novaEntrada,
  input  logic [3:0] andarOrigem,
  input  logic [3:0] andarDestino,
`ifdef PARADA_EMERG_EN
  input  logic       parar,
`endif
  output logic [3:0] andarAtual,
  output logic       sobe,
  output logic       desce,
  output logic       portaAberta,
  output logic       pedidoAceito,
  output logic       pedidoRejeitado,
  output logic       filaCheia,
  output logic       filaVazia,
  output logic [3:0] db_estado
);

  localparam int unsigned PW    = $clog2(FILA_PROF);
  localparam int unsigned CW    = PW + 1;
  localparam int unsigned T_MAX = (T_ANDAR > T_PORTA) ? T_ANDAR : T_PORTA;
  localparam int unsigned TW    = $clog2(T_MAX + 1);

  typedef enum logic [2:0] {
    INICIAL    = 3'd0,
    PARADO     = 3'd1,
    DECIDE     = 3'd2,
    SOBE       = 3'd3,
    DESCE      = 3'd4,
    PORTA      = 3'd5,
    REMOVE     = 3'd6,
    EMERGENCIA = 3'd7
  } estado_t;

  estado_t       estado, estadoProx;
  logic [TW-1:0] timer, timerProx;
  logic [3:0]    andarProx;
  logic          buscando, buscandoProx;
  logic          pop;

  logic [7:0]    mem [FILA_PROF];
  logic [PW-1:0] wrPtr, rdPtr;
  logic [CW-1:0] count, countProx;
  logic [7:0]    cabeca;
  logic [3:0]    alvo;
  logic          tentativa, valido, cheio, push, rejeita, portaProx;

`ifdef PARADA_EMERG_EN
  estado_t       estadoSalvo, salvoProx;
`endif

  // Head of the FIFO and the floor currently being targeted.
  assign cabeca = mem[rdPtr];
  assign alvo   = buscando ? cabeca[7:4] : cabeca[3:0];

  // Push decision uses the occupancy before any same-cycle pop.
  assign tentativa = novaEntrada && (estado != INICIAL);
  assign valido    = ({1'b0, andarOrigem} < 5'(NUM_ANDARES)) &&
                     ({1'b0, andarDestino} < 5'(NUM_ANDARES)) &&
                     (andarOrigem != andarDestino);
  assign cheio     = (count == CW'(FILA_PROF));
  assign push      = tentativa && !cheio && valido;
  assign rejeita   = tentativa && !push;
  assign countProx = count + CW'(push) - CW'(pop);

  // State register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) estado <= INICIAL;
    else       estado <= estadoProx;
  end

  // Next-state, timer, floor and phase logic.
  always_comb begin
    estadoProx   = estado;
    timerProx    = timer;
    andarProx    = andarAtual;
    buscandoProx = buscando;
    pop          = 1'b0;
`ifdef PARADA_EMERG_EN
    salvoProx    = estadoSalvo;
`endif
    case (estado)
      INICIAL: if (iniciar) estadoProx = PARADO;
      PARADO:  if (count != '0) estadoProx = DECIDE;
      DECIDE: begin
        timerProx = '0;
        if (alvo > andarAtual)      estadoProx = SOBE;
        else if (alvo < andarAtual) estadoProx = DESCE;
        else                        estadoProx = PORTA;
      end
      SOBE: begin
        if (timer == TW'(T_ANDAR - 1)) begin
          timerProx  = '0;
          estadoProx = DECIDE;
          if (andarAtual < 4'(NUM_ANDARES - 1)) andarProx = andarAtual + 4'd1;
        end else begin
          timerProx = timer + TW'(1);
        end
      end
      DESCE: begin
        if (timer == TW'(T_ANDAR - 1)) begin
          timerProx  = '0;
          estadoProx = DECIDE;
          if (andarAtual != 4'd0) andarProx = andarAtual - 4'd1;
        end else begin
          timerProx = timer + TW'(1);
        end
      end
      PORTA: begin
        if (timer == TW'(T_PORTA - 1)) begin
          timerProx = '0;
          if (buscando) begin
            buscandoProx = 1'b0;
            estadoProx   = DECIDE;
          end else begin
            estadoProx = REMOVE;
          end
        end else begin
          timerProx = timer + TW'(1);
        end
      end
      REMOVE: begin
        pop          = 1'b1;
        buscandoProx = 1'b1;
        estadoProx   = PARADO;
      end
`ifdef PARADA_EMERG_EN
      EMERGENCIA: if (!parar) estadoProx = estadoSalvo;
`endif
      default: estadoProx = INICIAL;
    endcase
`ifdef PARADA_EMERG_EN
    // Emergency stop freezes everything and remembers where to resume.
    if (parar && (estado == SOBE || estado == DESCE || estado == PORTA)) begin
      estadoProx   = EMERGENCIA;
      salvoProx    = estado;
      timerProx    = timer;
      andarProx    = andarAtual;
      buscandoProx = buscando;
    end
    portaProx = (estadoProx == PORTA) || ((estadoProx == EMERGENCIA) && portaAberta);
`else
    portaProx = (estadoProx == PORTA);
`endif
  end

  // Datapath registers and registered outputs.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      timer           <= '0;
      andarAtual      <= 4'd0;
      buscando        <= 1'b1;
      wrPtr           <= '0;
      rdPtr           <= '0;
      count           <= '0;
      sobe            <= 1'b0;
      desce           <= 1'b0;
      portaAberta     <= 1'b0;
      pedidoAceito    <= 1'b0;
      pedidoRejeitado <= 1'b0;
      filaCheia       <= 1'b0;
      filaVazia       <= 1'b1;
      db_estado       <= 4'd0;
`ifdef PARADA_EMERG_EN
      estadoSalvo     <= INICIAL;
`endif
    end else begin
      timer           <= timerProx;
      andarAtual      <= andarProx;
      buscando        <= buscandoProx;
      if (push) wrPtr <= wrPtr + PW'(1);
      if (pop)  rdPtr <= rdPtr + PW'(1);
      count           <= countProx;
      sobe            <= (estadoProx == SOBE);
      desce           <= (estadoProx == DESCE);
      portaAberta     <= portaProx;
      pedidoAceito    <= push;
      pedidoRejeitado <= rejeita;
      filaCheia       <= (countProx == CW'(FILA_PROF));
      filaVazia       <= (countProx == '0);
      db_estado       <= {1'b0, estadoProx};
`ifdef PARADA_EMERG_EN
      estadoSalvo     <= salvoProx;
`endif
    end
  end

  // Request storage; contents need no reset, the pointers qualify them.
  always_ff @(posedge clock) begin
    if (push) mem[wrPtr] <= {andarOrigem, andarDestino};
  end

endmodule

// File: tb/tb_controlador_elevador_fila.sv
// Bench for controlador_elevador_fila (NUM_ANDARES=8, FILA_PROF=4, T_ANDAR=4,
// T_PORTA=3). Request responses and door floors are predicted into queues
// when requests are driven and consumed when the DUT produces them.
module tb_controlador_elevador_fila;

  logic       clock, reset, iniciar, novaEntrada;
  logic [3:0] andarOrigem, andarDestino;
  logic [3:0] andarAtual, db_estado;
  logic       sobe, desce, portaAberta, pedidoAceito, pedidoRejeitado;
  logic       filaCheia, filaVazia;
`ifdef PARADA_EMERG_EN
  logic       parar;
`endif

  controlador_elevador_fila #(
    .NUM_ANDARES(8), .FILA_PROF(4), .T_ANDAR(4), .T_PORTA(3)
  ) dut (
    .clock(clock), .reset(reset), .iniciar(iniciar), .novaEntrada(novaEntrada),
    .andarOrigem(andarOrigem), .andarDestino(andarDestino),
`ifdef PARADA_EMERG_EN
    .parar(parar),
`endif
    .andarAtual(andarAtual), .sobe(sobe), .desce(desce), .portaAberta(portaAberta),
    .pedidoAceito(pedidoAceito), .pedidoRejeitado(pedidoRejeitado),
    .filaCheia(filaCheia), .filaVazia(filaVazia), .db_estado(db_estado)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;
  bit respQ[$];
  int portaQ[$];
  bit prevPorta = 1'b0;
  int portaLen = 0;
  int sobeCnt = 0;
  int desceCnt = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Advance to the next falling edge and score whatever the DUT produced.
  task automatic tick();
    bit e;
    int f;
    @(negedge clock);
    if (reset) begin
      prevPorta = 1'b0;
      portaLen  = 0;
    end else begin
      if (sobe)  sobeCnt++;
      if (desce) desceCnt++;
      if (pedidoAceito || pedidoRejeitado) begin
        chk("resp_esperada", 32'(respQ.size() != 0), 1);
        if (respQ.size() != 0) begin
          e = respQ.pop_front();
          chk("pedidoAceito", 32'(pedidoAceito), 32'(e));
          chk("pedidoRejeitado", 32'(pedidoRejeitado), 32'(!e));
        end
      end
      if (portaAberta && !prevPorta) begin
        chk("porta_esperada", 32'(portaQ.size() != 0), 1);
        if (portaQ.size() != 0) begin
          f = portaQ.pop_front();
          chk("andar_porta", 32'(andarAtual), 32'(f));
        end
      end
      if (portaAberta) portaLen++;
      else if (prevPorta) begin
        chk("duracao_porta", 32'(portaLen), 3);
        portaLen = 0;
      end
      prevPorta = portaAberta;
    end
  endtask

  // One-cycle request strobe; returns at the falling edge where the response shows.
  task automatic pedido(input int o, input int d, input bit aceito);
    andarOrigem  = 4'(o);
    andarDestino = 4'(d);
    novaEntrada  = 1'b1;
    respQ.push_back(aceito);
    if (aceito) begin
      portaQ.push_back(o);
      portaQ.push_back(d);
    end
    tick();
    novaEntrada = 1'b0;
  endtask

  task automatic esperaOcioso(input int limite);
    int n = 0;
    do begin
      tick();
      n++;
    end while (!(db_estado == 4'd1 && filaVazia) && n < limite);
    chk("ocioso_estado", 32'(db_estado), 1);
    chk("ocioso_vazia", 32'(filaVazia), 1);
    chk("scoreboard_portas", 32'(portaQ.size()), 0);
    chk("scoreboard_resp", 32'(respQ.size()), 0);
  endtask

  task automatic liga();
    iniciar = 1'b1;
    tick();
    iniciar = 1'b0;
    chk("iniciar_parado", 32'(db_estado), 1);
  endtask

  task automatic chkRepouso(input string tag);
    chk({tag, "_andar"}, 32'(andarAtual), 0);
    chk({tag, "_sobe"}, 32'(sobe), 0);
    chk({tag, "_desce"}, 32'(desce), 0);
    chk({tag, "_porta"}, 32'(portaAberta), 0);
    chk({tag, "_aceito"}, 32'(pedidoAceito), 0);
    chk({tag, "_rejeitado"}, 32'(pedidoRejeitado), 0);
    chk({tag, "_cheia"}, 32'(filaCheia), 0);
    chk({tag, "_vazia"}, 32'(filaVazia), 1);
    chk({tag, "_estado"}, 32'(db_estado), 0);
  endtask

  initial begin
    int n;
    reset = 1'b1; iniciar = 1'b0; novaEntrada = 1'b0;
    andarOrigem = 4'd0; andarDestino = 4'd0;
`ifdef PARADA_EMERG_EN
    parar = 1'b0;
`endif
    tick(); tick();
    reset = 1'b0;
    tick();
    chkRepouso("reset");

    // Strobes in INICIAL are ignored: no pulse, FIFO untouched.
    andarOrigem = 4'd1; andarDestino = 4'd2; novaEntrada = 1'b1;
    tick();
    novaEntrada = 1'b0;
    tick();
    chk("inicial_vazia", 32'(filaVazia), 1);
    chk("inicial_estado", 32'(db_estado), 0);
    liga();

    // 1: request 0->3 from floor 0.
    sobeCnt = 0;
    pedido(0, 3, 1);
    chk("t1_parado", 32'(db_estado), 1);
    tick();
    chk("t1_decide", 32'(db_estado), 2);
    chk("t1_porta_fechada", 32'(portaAberta), 0);
    tick();
    chk("t1_porta_estado", 32'(db_estado), 5);
    chk("t1_porta_aberta", 32'(portaAberta), 1);
    esperaOcioso(500);
    chk("t1_andar", 32'(andarAtual), 3);
    chk("t1_sobe_ciclos", 32'(sobeCnt), 12);

    // 2: invalid requests, including origem == NUM_ANDARES.
    pedido(5, 5, 0);
    chk("t2_vazia_a", 32'(filaVazia), 1);
    pedido(2, 9, 0);
    chk("t2_vazia_b", 32'(filaVazia), 1);
    pedido(8, 2, 0);
    chk("t2_vazia_c", 32'(filaVazia), 1);
    chk("t2_estado", 32'(db_estado), 1);

    // 3: five back-to-back requests, the fifth hits a full FIFO.
    pedido(1, 4, 1);
    pedido(6, 2, 1);
    pedido(0, 7, 1);
    pedido(5, 3, 1);
    chk("t3_cheia", 32'(filaCheia), 1);
    pedido(2, 6, 0);
    chk("t3_cheia_pos", 32'(filaCheia), 1);
    esperaOcioso(3000);
    chk("t3_andar", 32'(andarAtual), 3);
    chk("t3_cheia_final", 32'(filaCheia), 0);

    // 4: reset while descending from floor 6.
    pedido(6, 0, 1);
    n = 0;
    while (db_estado != 4'd4 && n < 500) begin
      tick();
      n++;
    end
    chk("t4_desce", 32'(db_estado), 4);
    chk("t4_andar6", 32'(andarAtual), 6);
    reset = 1'b1;
    tick();
    portaQ.delete();
    chkRepouso("t4_reset");
    reset = 1'b0;
    tick();
    chk("t4_pos_reset", 32'(db_estado), 0);
    liga();

    // 5: request 7->0 from floor 0 (full span both ways).
    sobeCnt = 0; desceCnt = 0;
    pedido(7, 0, 1);
    esperaOcioso(1000);
    chk("t5_sobe_ciclos", 32'(sobeCnt), 28);
    chk("t5_desce_ciclos", 32'(desceCnt), 28);
    chk("t5_andar", 32'(andarAtual), 0);

`ifdef PARADA_EMERG_EN
    // 6: emergency stop at timer count 2 while climbing.
    pedido(2, 3, 1);
    tick();
    tick();
    chk("t6_sobe", 32'(db_estado), 3);
    tick();
    tick();
    parar = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("t6_emerg", 32'(db_estado), 7);
      chk("t6_andar_parado", 32'(andarAtual), 0);
      chk("t6_sobe_zero", 32'(sobe), 0);
    end
    parar = 1'b0;
    tick();
    chk("t6_retoma", 32'(db_estado), 3);
    tick();
    chk("t6_ultimo_ciclo", 32'(andarAtual), 0);
    tick();
    chk("t6_andar1", 32'(andarAtual), 1);
    chk("t6_decide", 32'(db_estado), 2);
    esperaOcioso(500);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
